fp32_serial_rx: RTL and testbench

FP32_SERIAL_RX -- requirements
Module: fp32_serial_rx

---
 rtl/fp32_serial_rx.sv | 114 +++++++++++
 tb/tb_fp32_serial_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp32_serial_rx.sv
// Serial-to-parallel receiver for one IEEE-754 single-precision word per frame.
// Shifts in 32 bits after a Start strobe, then presents the raw word plus its unpacked fields and class.
module fp32_serial_rx #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        Clk,
  input  logic        Clear,
  input  logic        D,
  input  logic        Start,
  output logic        Busy,
  output logic        Valid,
  output logic [31:0] Word,
  output logic        Sign,
  output logic [7:0]  Exponent,
  output logic [23:0] Mantissa,
  output logic        IsZero,
  output logic        IsDenorm,
  output logic        IsInf,
  output logic        IsNaN
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  bit_cnt;
  logic [31:0] shift_reg;
  logic [31:0] shift_next;
  logic [31:0] word_q;
  logic        capture;
  logic        last_bit;
  logic        frame_start;

  // Start only opens a frame outside SHIFT; a strobe mid-frame is ignored.
  assign frame_start = (state != SHIFT) && Start;
  assign capture     = (state == SHIFT) || frame_start;
  assign last_bit    = (state == SHIFT) && (bit_cnt == 6'd31);
  assign shift_next  = MSB_FIRST ? {shift_reg[30:0], D} : {D, shift_reg[31:1]};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 6'd31) state_next = DONE;
      DONE:    state_next = Start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy  = 1'b0;
    Valid = 1'b0;
    unique case (state)
      SHIFT:   Busy  = 1'b1;
      DONE:    Valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the shift register and word are reset explicitly so a partial frame can never leak out.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      word_q    <= '0;
    end else begin
      if (capture) begin
        shift_reg <= shift_next;
      end
      if (frame_start) begin
        bit_cnt <= 6'd1;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + 6'd1;
      end else begin
        bit_cnt <= '0;
      end
      // The 32nd bit is folded in directly so the word lands on the edge that enters DONE.
      if (last_bit) begin
        word_q <= shift_next;
      end
    end
  end

  logic exp_zero;
  logic exp_ones;
  logic frac_nz;

  assign Word     = word_q;
  assign Sign     = word_q[31];
  assign Exponent = word_q[30:23];
  assign exp_zero = (word_q[30:23] == 8'h00);
  assign exp_ones = (word_q[30:23] == 8'hFF);
  assign frac_nz  = |word_q[22:0];
  assign Mantissa = {~exp_zero, word_q[22:0]};
  assign IsZero   = exp_zero && !frac_nz;
  assign IsDenorm = exp_zero && frac_nz;
  assign IsInf    = exp_ones && !frac_nz;
  assign IsNaN    = exp_ones && frac_nz;

endmodule

// File: tb/tb_fp32_serial_rx.sv
// Bench for fp32_serial_rx: an MSB-first and an LSB-first instance receive the same words in lockstep,
// and a scoreboard of expected words with their due cycle is checked every cycle.
module tb_fp32_serial_rx;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic d_msb = 1'b0;
  logic d_lsb = 1'b0;

  logic        busy_m, valid_m, sign_m, zero_m, denorm_m, inf_m, nan_m;
  logic [31:0] word_m;
  logic [7:0]  exp_m;
  logic [23:0] mant_m;
  logic        busy_l, valid_l, sign_l, zero_l, denorm_l, inf_l, nan_l;
  logic [31:0] word_l;
  logic [7:0]  exp_l;
  logic [23:0] mant_l;

  always #5 clk = ~clk;

  fp32_serial_rx #(.MSB_FIRST(1'b1)) dut_msb (
    .Clk(clk), .Clear(clear), .D(d_msb), .Start(start),
    .Busy(busy_m), .Valid(valid_m), .Word(word_m), .Sign(sign_m),
    .Exponent(exp_m), .Mantissa(mant_m),
    .IsZero(zero_m), .IsDenorm(denorm_m), .IsInf(inf_m), .IsNaN(nan_m)
  );

  fp32_serial_rx #(.MSB_FIRST(1'b0)) dut_lsb (
    .Clk(clk), .Clear(clear), .D(d_lsb), .Start(start),
    .Busy(busy_l), .Valid(valid_l), .Word(word_l), .Sign(sign_l),
    .Exponent(exp_l), .Mantissa(mant_l),
    .IsZero(zero_l), .IsDenorm(denorm_l), .IsInf(inf_l), .IsNaN(nan_l)
  );

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  logic [31:0] last_word = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected unpacked view of a raw word, built from the IEEE-754 field definitions.
  task automatic check_outputs(input string tag, input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] f;
    logic [23:0] mant;
    logic [3:0]  flags;
    e     = w[30:23];
    f     = w[22:0];
    mant  = {(e != 8'h00), f};
    flags = {(e == 8'h00) && (f == 23'd0), (e == 8'h00) && (f != 23'd0),
             (e == 8'hFF) && (f == 23'd0), (e == 8'hFF) && (f != 23'd0)};
    check({tag, "_word_m"},  word_m, w);
    check({tag, "_word_l"},  word_l, w);
    check({tag, "_sign_m"},  32'(sign_m), 32'(w[31]));
    check({tag, "_sign_l"},  32'(sign_l), 32'(w[31]));
    check({tag, "_exp_m"},   32'(exp_m), 32'(e));
    check({tag, "_exp_l"},   32'(exp_l), 32'(e));
    check({tag, "_mant_m"},  32'(mant_m), 32'(mant));
    check({tag, "_mant_l"},  32'(mant_l), 32'(mant));
    check({tag, "_flags_m"}, 32'({zero_m, denorm_m, inf_m, nan_m}), 32'(flags));
    check({tag, "_flags_l"}, 32'({zero_l, denorm_l, inf_l, nan_l}), 32'(flags));
  endtask

  // Runs once per cycle, just after the edge: control outputs vs. the scoreboard, data vs. the held word.
  task automatic monitor();
    logic exp_valid;
    logic exp_busy;
    exp_valid = (sb.size() != 0) && (sb[0].due == cyc);
    exp_busy  = (sb.size() != 0) && (cyc > sb[0].due - 32) && (cyc < sb[0].due);
    check("valid_m", 32'(valid_m), 32'(exp_valid));
    check("valid_l", 32'(valid_l), 32'(exp_valid));
    check("busy_m",  32'(busy_m),  32'(exp_busy));
    check("busy_l",  32'(busy_l),  32'(exp_busy));
    if (exp_valid) begin
      last_word = sb.pop_front().word;
    end
    check_outputs("out", last_word);
  endtask

  task automatic cycle(input logic s, input logic dm, input logic dl);
    start = s;
    d_msb = dm;
    d_lsb = dl;
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      logic r;
      r = 1'($urandom);
      cycle(1'b0, r, r);
    end
  endtask

  // Sends nbits of w; both instances see the same bit index each cycle, in their own order.
  task automatic send_frame(input logic [31:0] w, input int restart_at = -1, input int nbits = 32);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) sb.push_back('{word: w, due: cyc + 32});
      cycle((i == 0) || (i == restart_at), w[31 - i], w[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;

    // Reset values while Clear is held low.
    #12;
    check("rst_busy", 32'({busy_m, busy_l}), 32'd0);
    check("rst_valid", 32'({valid_m, valid_l}), 32'd0);
    check_outputs("rst", 32'h0000_0000);
    check("rst_zero", 32'({zero_m, zero_l}), 32'd3);

    // Release mid-cycle; the very next rising edge takes the Start.
    @(negedge clk);
    clear = 1'b1;

    send_frame(32'h3F80_0000);
    idle(2);
    check("one_exp_m",   32'(exp_m),  32'h7F);
    check("one_mant_m",  32'(mant_m), 32'h80_0000);
    check("one_flags_m", 32'({zero_m, denorm_m, inf_m, nan_m}), 32'h0);
    check("one_word_l",  word_l, 32'h3F80_0000);
    check("one_exp_l",   32'(exp_l),  32'h7F);

    send_frame(32'h8000_0000);
    idle(1);
    check("negzero", 32'({sign_m, zero_m, denorm_m, inf_m, nan_m}), 32'b11000);
    send_frame(32'h7F80_0000);
    idle(1);
    check("inf", 32'({zero_m, denorm_m, inf_m, nan_m}), 32'b0010);
    send_frame(32'h7FC0_0000);
    idle(1);
    check("nan", 32'({zero_m, denorm_m, inf_m, nan_m}), 32'b0001);
    send_frame(32'h0000_0001);
    idle(1);
    check("denorm", 32'({zero_m, denorm_m, inf_m, nan_m}), 32'b0100);
    check("denorm_mant", 32'(mant_m), 32'h00_0001);

    // Back-to-back: second Start lands in the DONE cycle of the first frame.
    send_frame(32'hC049_0FDB);
    check("b2b_first_valid", 32'(valid_m), 32'd1);
    check("b2b_first_word",  word_m, 32'hC049_0FDB);
    send_frame(32'h0000_0000);
    check("b2b_second_valid", 32'(valid_m), 32'd1);
    check("b2b_second_word",  word_m, 32'h0000_0000);
    idle(3);

    // A second Start at bit 10 must not restart the frame.
    send_frame(32'h4120_0000, 10);
    idle(2);
    check("restart_word", word_m, 32'h4120_0000);

    // Reset in the middle of a frame.
    send_frame(32'h3F80_0000, -1, 15);
    clear = 1'b0;
    #1;
    check("midrst_busy",  32'({busy_m, busy_l}), 32'd0);
    check("midrst_valid", 32'({valid_m, valid_l}), 32'd0);
    check("midrst_word",  word_m, 32'h0);
    check("midrst_zero",  32'(zero_m), 32'd1);
    sb.delete();
    last_word = 32'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    idle(40);
    send_frame(32'h4000_0000);
    idle(1);
    check("post_rst_exp", 32'(exp_m), 32'h80);
    check("post_rst_word_l", word_l, 32'h4000_0000);

    // A few random words streamed back-to-back.
    for (int k = 0; k < 3; k++) begin
      rnd = $urandom;
      send_frame(rnd);
    end
    idle(4);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
